// File: rtl/prog_delay_multi.sv
// Multi-channel programmable delay line: synchronised input edges are queued with due timestamps
// and replayed after per-channel rise/fall delays; configured through a byte register map.
module prog_delay_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_100mhz,
    input  logic              rst_n_sync,
    input  logic              reg_write_enable,
    input  logic              reg_read_enable,
    input  logic [7:0]        reg_address,
    input  logic [7:0]        reg_write_data,
    output logic [7:0]        reg_read_data,
    input  logic [NUM_CH-1:0] signal_in,
    output logic [NUM_CH-1:0] delayed_out,
    output logic [NUM_CH-1:0] overflow,
    output logic [NUM_CH-1:0] busy
);
    localparam int unsigned TW = CNT_WIDTH + 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned HW = CNT_WIDTH - 8;

    logic [CNT_WIDTH-1:0] rise_q [NUM_CH];
    logic [CNT_WIDTH-1:0] fall_q [NUM_CH];
    logic [NUM_CH-1:0]    enable_q, invert_q, overflow_q, overflow_set, overflow_clr;
    logic [TW-1:0]        now_q;

    assign overflow_clr = (reg_write_enable && reg_address == 8'h42) ?
                          reg_write_data[NUM_CH-1:0] : '0;
    assign overflow     = overflow_q;

    always_ff @(posedge clk_100mhz or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rise_q[c] <= '0;
                fall_q[c] <= '0;
            end
            enable_q   <= '0;
            invert_q   <= '0;
            overflow_q <= '0;
            now_q      <= '0;
        end else begin
            now_q      <= now_q + TW'(1);
            // Set wins over a same-cycle W1C
            overflow_q <= (overflow_q & ~overflow_clr) | overflow_set;
            if (reg_write_enable) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (reg_address == 8'(c * 4 + 0)) rise_q[c][7:0] <= reg_write_data;
                    if (reg_address == 8'(c * 4 + 1))
                        rise_q[c][CNT_WIDTH-1:8] <= reg_write_data[HW-1:0];
                    if (reg_address == 8'(c * 4 + 2)) fall_q[c][7:0] <= reg_write_data;
                    if (reg_address == 8'(c * 4 + 3))
                        fall_q[c][CNT_WIDTH-1:8] <= reg_write_data[HW-1:0];
                end
                if (reg_address == 8'h40) enable_q <= reg_write_data[NUM_CH-1:0];
                if (reg_address == 8'h41) invert_q <= reg_write_data[NUM_CH-1:0];
            end
        end
    end

    always_comb begin
        reg_read_data = '0;
        if (reg_read_enable) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (reg_address == 8'(c * 4 + 0)) reg_read_data = rise_q[c][7:0];
                if (reg_address == 8'(c * 4 + 1)) reg_read_data = 8'(rise_q[c][CNT_WIDTH-1:8]);
                if (reg_address == 8'(c * 4 + 2)) reg_read_data = fall_q[c][7:0];
                if (reg_address == 8'(c * 4 + 3)) reg_read_data = 8'(fall_q[c][CNT_WIDTH-1:8]);
            end
            if (reg_address == 8'h40) reg_read_data = 8'(enable_q);
            if (reg_address == 8'h41) reg_read_data = 8'(invert_q);
            if (reg_address == 8'h42) reg_read_data = 8'(overflow_q);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   last_q, held_q, out_q;
        logic [TW-1:0]          due_q [DEPTH];
        logic [DEPTH-1:0]       lvl_q;
        logic [AW-1:0]          wr_q, rd_q, tail_idx;
        logic [AW:0]            cnt_q;
        logic                   s, edge_det, pop, push;
        logic [TW-1:0]          delay, due_new, tail_due, diff;

        assign s = sync_q[SYNC_STAGES-1];

        always_comb begin
            edge_det = enable_q[g] && (s != last_q);
            delay    = TW'(s ? rise_q[g] : fall_q[g]);
            if (delay == '0) delay = TW'(1);
            tail_idx = wr_q - AW'(1);
            tail_due = due_q[tail_idx];
            due_new  = now_q + delay;
            diff     = due_new - tail_due;
            // Not strictly later than the tail: slot in one cycle behind it to keep order
            if (cnt_q != '0 && (diff[TW-1] || diff == '0)) due_new = tail_due + TW'(1);
            pop  = enable_q[g] && (cnt_q != '0) && (due_q[rd_q] == now_q);
            push = edge_det && ((cnt_q != (AW + 1)'(DEPTH)) || pop);
            overflow_set[g] = edge_det && !push;
        end

        always_ff @(posedge clk_100mhz or negedge rst_n_sync) begin
            if (!rst_n_sync) begin
                sync_q <= '0;
                last_q <= 1'b0;
                held_q <= 1'b0;
                out_q  <= 1'b0;
                lvl_q  <= '0;
                wr_q   <= '0;
                rd_q   <= '0;
                cnt_q  <= '0;
                for (int i = 0; i < DEPTH; i++) due_q[i] <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in[g]};
                last_q <= s;
                if (pop) held_q <= lvl_q[rd_q];
                out_q <= (pop ? lvl_q[rd_q] : held_q) ^ invert_q[g];
                if (!enable_q[g]) begin
                    wr_q  <= '0;
                    rd_q  <= '0;
                    cnt_q <= '0;
                end else begin
                    if (push) begin
                        due_q[wr_q] <= due_new;
                        lvl_q[wr_q] <= s;
                        wr_q        <= wr_q + AW'(1);
                    end
                    if (pop) rd_q <= rd_q + AW'(1);
                    if (push && !pop) cnt_q <= cnt_q + (AW + 1)'(1);
                    else if (pop && !push) cnt_q <= cnt_q - (AW + 1)'(1);
                end
            end
        end

        assign delayed_out[g] = out_q;
        assign busy[g]        = (cnt_q != '0);
    end

endmodule
